ara_inval_broadcaster: RTL
==========================

Name: ara_inval_broadcaster

Overview:
- Coherence block between Ara's wide AXI write-address path and NrCores scalar cores.
- Buffers incoming AW requests and expands each burst into the L1 cache lines it covers.
- Broadcasts one invalidation per line to every coherence-enabled core, then forwards the AW downstream.
- Successor to the single-core, single-line invalidation filter: parametrised core count, multi-line bursts, per-core handshakes, request queue.

Parameters:
- NrCores, 4, number of scalar cores receiving invalidations (1..8)
- AddrWidth, 64, AXI address width
- L1LineBytes, 16, L1 D-cache line size in bytes (power of two, ≥8)
- FifoDepth, 4, AW request queue depth (power of two, ≥2)
- MetaWidth, 32, width of opaque AW side fields (id, cache, prot, user…), passed through unchanged

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  NrCores  per-core coherence enable
- aw_valid_i  in  1  upstream AW valid
- aw_ready_o  out  1  upstream AW ready
- aw_addr_i  in  AddrWidth  AW address
- aw_len_i  in  8  AW beats minus one
- aw_size_i  in  3  log2 bytes per beat
- aw_burst_i  in  2  AXI burst type
- aw_meta_i  in  MetaWidth  opaque AW fields
- aw_valid_o  out  1  downstream AW valid
- aw_ready_i  in  1  downstream AW ready
- aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_meta_o  out  as inputs  head request, unchanged
- inval_addr_o  out  AddrWidth  line-aligned invalidation address, shared by all cores
- inval_valid_o  out  NrCores  per-core invalidation valid
- inval_ready_i  in  NrCores  per-core invalidation ready
- busy_o  out  1  FIFO non-empty or state ≠ IDLE

Behaviour:
- Reset (rst_i high at a clock edge):
  - FIFO empty, state IDLE.
  - aw_valid_o=0, inval_valid_o=0, busy_o=0, aw_ready_o=1 from the following cycle.
  - Invalidations in flight mid-operation and queued requests are dropped, with no partial handshakes resumed.
- Upstream:
  - aw_ready_o = !fifo_full; it does not depend on a same-cycle pop.
  - Push on aw_valid_i && aw_ready_o.
  - Output fields always reflect the FIFO head.
- Line range, computed in IDLE from the head request:
  - total = (len+1)<<size.
  - INCR: first = addr & ~(L1LineBytes-1); last = (addr+total-1) & ~(L1LineBytes-1).
  - FIXED: last = (addr+(1<<size)-1) aligned down to a line.
  - WRAP: base = addr & ~(total-1); first = base aligned down to a line; last = (base+total-1) aligned down to a line.
  - If addr+total-1 overflows AddrWidth, last clamps to the top line. No wrap to zero.
- FSM:
  - IDLE
    - Head valid → latch mask = en_i, latch cur=first and last.
    - mask==0 → FWD; else → INVAL.
  - INVAL
    - inval_addr_o=cur; inval_valid_o[k] = mask[k] & !done[k].
    - done[k] sets on inval_valid_o[k]&inval_ready_i[k].
    - A core's valid stays high until its own handshake and never drops early.
    - Line completes when (done | handshake_this_cycle) == mask.
    - On completion: cur==last → FWD; else cur+=L1LineBytes, done cleared, next line driven the following cycle.
  - FWD
    - aw_valid_o=1, payload held stable.
    - On aw_ready_i: pop FIFO → IDLE.
- en_i changes after latching do not affect the current request. They take effect for the next request.
- Latency, empty FIFO, all readies high, single-line request:
  - push cycle 0 → IDLE sees head cycle 1 → inval_valid_o cycle 2 → aw_valid_o cycle 3.
  - Each additional line adds 1 cycle.
- Simultaneous events: push and pop in the same cycle are both allowed when the FIFO is not full. Occupancy is unchanged.
- Ordering: strictly in order. A downstream AW is never issued before all of its lines are invalidated on all latched cores.

Test Plan:
- Reset mid-INVAL: 3-line burst, core1 ready=0, assert rst_i → next cycle inval_valid_o=0, aw_valid_o=0, busy_o=0; no AW emitted.
- INCR, addr=0x1008, len=3, size=3 (32 B), L1LineBytes=16, en_i=4'b1111, readies=1 → inval_addr_o 0x1000, 0x1010, 0x1020 on consecutive cycles; then one AW with addr 0x1008.
- Staggered readies, en_i=4'b0101: core0 ready cycle 2, core2 ready cycle 5 → inval_valid_o[0] drops after cycle 2, [2] held until cycle 5; [1] and [3] never asserted; AW follows cycle 6.
- en_i=0 → no inval_valid_o; AW forwarded 2 cycles after push; en_i toggled mid-burst → latched mask unchanged.
- Back-pressure, aw_ready_i=0 for 10 cycles, 5 pushes with FifoDepth=4 → aw_ready_o low after 4 accepted; in-order AW output once released.
- WRAP, addr=0x2038, len=3, size=3 → lines 0x2020 and 0x2030 only; FIXED, len=7 → single line.

Source files
------------

// File: rtl/ara_inval_broadcaster.sv
// rtl/ara_inval_broadcaster.sv - AW queue that broadcasts per-line L1 invalidations to scalar cores before forwarding
module ara_inval_broadcaster #(
  parameter int unsigned NrCores     = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineBytes = 16,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned MetaWidth   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NrCores-1:0]   en_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [7:0]           aw_len_i,
  input  logic [2:0]           aw_size_i,
  input  logic [1:0]           aw_burst_i,
  input  logic [MetaWidth-1:0] aw_meta_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic [7:0]           aw_len_o,
  output logic [2:0]           aw_size_o,
  output logic [1:0]           aw_burst_o,
  output logic [MetaWidth-1:0] aw_meta_o,
  output logic [AddrWidth-1:0] inval_addr_o,
  output logic [NrCores-1:0]   inval_valid_o,
  input  logic [NrCores-1:0]   inval_ready_i,
  output logic                 busy_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(L1LineBytes - 1);
  localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineBytes);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [MetaWidth-1:0] meta;
  } aw_req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_INVAL, ST_FWD} state_e;

  aw_req_t              fifo_mem [FifoDepth];
  aw_req_t              req_in;
  aw_req_t              head;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 fifo_full, fifo_empty, push, pop;

  state_e               state_q;
  logic [NrCores-1:0]   mask_q;
  logic [NrCores-1:0]   inval_valid_q;
  logic                 aw_valid_q;
  logic [AddrWidth-1:0] cur_q, last_q;

  logic [15:0]          total, beat, span;
  logic [AddrWidth-1:0] lo, first_line, last_line;
  logic [AddrWidth:0]   hi;

  assign req_in     = '{addr: aw_addr_i, len: aw_len_i, size: aw_size_i, burst: aw_burst_i, meta: aw_meta_i};
  assign head       = fifo_mem[rd_ptr_q];
  assign fifo_full  = (count_q == (PtrW+1)'(FifoDepth));
  assign fifo_empty = (count_q == '0);
  assign aw_ready_o = !fifo_full;
  assign push       = aw_valid_i && !fifo_full;
  assign pop        = aw_valid_q && aw_ready_i;

  assign aw_valid_o    = aw_valid_q;
  assign aw_addr_o     = head.addr;
  assign aw_len_o      = head.len;
  assign aw_size_o     = head.size;
  assign aw_burst_o    = head.burst;
  assign aw_meta_o     = head.meta;
  assign inval_addr_o  = cur_q;
  assign inval_valid_o = inval_valid_q;
  assign busy_o        = !fifo_empty || (state_q != ST_IDLE);

  // Queue storage: written on push, no reset needed since occupancy gates reads
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= req_in;
  end

  // Queue pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + (PtrW+1)'(1);
      else if (!push && pop) count_q <= count_q - (PtrW+1)'(1);
    end
  end

  // Byte range touched by the head burst, reduced to first and last cache line
  always_comb begin
    total = ({8'd0, head.len} + 16'd1) << head.size;
    beat  = 16'd1 << head.size;
    lo    = head.addr;
    span  = total;
    case (head.burst)
      2'b00:   span = beat;
      2'b10:   lo   = head.addr & ~(AddrWidth'(total) - AddrWidth'(1));
      default: ;
    endcase
    hi         = {1'b0, lo} + (AddrWidth+1)'(span) - (AddrWidth+1)'(1);
    first_line = lo & LineMask;
    // Saturate at the top line instead of wrapping past the end of the address space
    last_line  = hi[AddrWidth] ? LineMask : (hi[AddrWidth-1:0] & LineMask);
  end

  // Sequencer: latch head, walk lines with per-core handshakes, then forward the AW
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      inval_valid_q <= '0;
      aw_valid_q    <= 1'b0;
      cur_q         <= '0;
      last_q        <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mask_q <= en_i;
            cur_q  <= first_line;
            last_q <= last_line;
            if (en_i == '0) begin
              state_q    <= ST_FWD;
              aw_valid_q <= 1'b1;
            end else begin
              state_q       <= ST_INVAL;
              inval_valid_q <= en_i;
            end
          end
        end
        ST_INVAL: begin
          if ((inval_valid_q & ~inval_ready_i) == '0) begin
            if (cur_q == last_q) begin
              state_q       <= ST_FWD;
              aw_valid_q    <= 1'b1;
              inval_valid_q <= '0;
            end else begin
              cur_q         <= cur_q + LineStep;
              inval_valid_q <= mask_q;
            end
          end else begin
            inval_valid_q <= inval_valid_q & ~inval_ready_i;
          end
        end
        ST_FWD: begin
          if (aw_ready_i) begin
            state_q    <= ST_IDLE;
            aw_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
